// File: rtl/alu_issue_ctrl_pkg.sv
// rtl/alu_issue_ctrl_pkg.sv - opcode constants, result-entry layout and helpers
// shared by the ALU issue controller and its ALU.
package alu_issue_ctrl_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_SHL = 4'd4;
  localparam logic [3:0] OP_ROR = 4'd7;
  localparam logic [3:0] OP_AND = 4'd8;
  localparam logic [3:0] OP_GT  = 4'd14;

  localparam int N_SUPPORTED = 8;
  localparam logic [3:0] SUPPORTED_OPS [N_SUPPORTED] = '{
    OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_SHL, OP_ROR, OP_AND, OP_GT
  };

  localparam int ENTRY_W = 7;

  typedef struct packed {
    logic       err;
    logic       zero;
    logic       carry;
    logic [3:0] result;
  } result_entry_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

  function automatic logic is_supported(input logic [3:0] sel);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_SUPPORTED; i++) begin
      if (SUPPORTED_OPS[i] == sel) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/alu_fixed.sv
// rtl/alu_fixed.sv - combinational 4-bit ALU; carry is bit 4 of the 5-bit
// result for arithmetic ops and the shifted-out bit for shift-left.
module alu_fixed
  import alu_issue_ctrl_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] sel,
  output logic [3:0] result,
  output logic       carry
);

  logic [4:0] wide;
  logic [7:0] prod;

  always_comb begin
    wide = 5'd0;
    prod = {4'd0, a} * {4'd0, b};
    case (sel)
      OP_ADD:  wide = {1'b0, a} + {1'b0, b};
      OP_SUB:  wide = {1'b0, a} - {1'b0, b};
      OP_MUL:  wide = prod[4:0];
      // Divide-by-zero yields 0 here; the controller substitutes its own error entry.
      OP_DIV:  wide = (b == 4'd0) ? 5'd0 : {1'b0, a / b};
      OP_SHL:  wide = {a[3], a[2:0], 1'b0};
      OP_ROR:  wide = {1'b0, a[0], a[3:1]};
      OP_AND:  wide = {1'b0, a & b};
      OP_GT:   wide = {4'd0, (a > b)};
      default: wide = 5'd0;
    endcase
  end

  assign result = wide[3:0];
  assign carry  = wide[4];

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - two-state issue controller: accepts one ALU op,
// executes it for one cycle and queues the result in a small FIFO.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int OUT_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  input  logic [3:0] in_sel,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_result,
  output logic       out_carry,
  output logic       out_zero,
  output logic       out_err,
  output logic       busy,
  output logic [7:0] op_count
);

  localparam int PTR_W = $clog2(OUT_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  state_t              state;
  logic [3:0]          a_q;
  logic [3:0]          b_q;
  logic [3:0]          sel_q;
  result_entry_t       mem [OUT_DEPTH];
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    wr_ptr;
  logic [CNT_W-1:0]    count;
  logic                fresh;

  logic [3:0]          alu_result;
  logic                alu_carry;
  result_entry_t       push_entry;
  result_entry_t       head;
  logic                accept;
  logic                push;
  logic                pop;

  alu_fixed u_alu (
    .a      (a_q),
    .b      (b_q),
    .sel    (sel_q),
    .result (alu_result),
    .carry  (alu_carry)
  );

  always_comb begin
    push_entry = '0;
    if (!is_supported(sel_q)) begin
      push_entry.err  = 1'b1;
      push_entry.zero = 1'b1;
    end else if (sel_q == OP_DIV && b_q == 4'd0) begin
      push_entry.err    = 1'b1;
      push_entry.result = 4'hF;
    end else begin
      push_entry.result = alu_result;
      push_entry.carry  = alu_carry;
      push_entry.zero   = (alu_result == 4'd0);
    end
  end

  // A result written into an empty buffer is presented from the following cycle.
  assign in_ready  = (state == ST_IDLE) && (count < CNT_W'(OUT_DEPTH));
  assign accept    = in_valid && in_ready;
  assign push      = (state == ST_EXEC);
  assign out_valid = (count != '0) && !fresh;
  assign pop       = out_valid && out_ready;
  assign head      = mem[rd_ptr];
  assign busy      = (state != ST_IDLE) || (count != '0);

  assign out_result = out_valid ? head.result : 4'd0;
  assign out_carry  = out_valid ? head.carry  : 1'b0;
  assign out_zero   = out_valid ? head.zero   : 1'b0;
  assign out_err    = out_valid ? head.err    : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      a_q      <= 4'd0;
      b_q      <= 4'd0;
      sel_q    <= 4'd0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      fresh    <= 1'b0;
      op_count <= 8'd0;
      for (int i = 0; i < OUT_DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            a_q   <= in_a;
            b_q   <= in_b;
            sel_q <= in_sel;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      fresh <= push && (count == '0);

      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
        op_count    <= op_count + 8'd1;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);

      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - self-checking bench for alu_issue_ctrl with
// directed scenarios and a randomized queue-based reference model.
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic [3:0] in_sel;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_result;
  logic       out_carry;
  logic       out_zero;
  logic       out_err;
  logic       busy;
  logic [7:0] op_count;

  int errors = 0;
  int checks = 0;
  int exp_ops = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.OUT_DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_sel     (in_sel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_carry  (out_carry),
    .out_zero   (out_zero),
    .out_err    (out_err),
    .busy       (busy),
    .op_count   (op_count)
  );

  wire [6:0] dut_entry = {out_err, out_zero, out_carry, out_result};

  // Expected entry {err, zero, carry, result} from plain integer arithmetic.
  function automatic logic [6:0] ref_entry(input int a, input int b, input int sel);
    int r;
    int c;
    r = 0;
    case (sel)
      0:  r = (a + b) % 32;
      1:  r = (a - b + 32) % 32;
      2:  r = (a * b) % 32;
      3:  begin
            if (b == 0) return 7'b1001111;
            r = a / b;
          end
      4:  r = (a * 2) % 16 + (a / 8) * 16;
      7:  r = a / 2 + (a % 2) * 8;
      8:  r = a & b;
      14: r = (a > b) ? 1 : 0;
      default: return 7'b1100000;
    endcase
    c = r / 16;
    r = r % 16;
    return {1'b0, (r == 0), c[0], r[3:0]};
  endfunction

  task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [3:0] sel);
    bit got;
    got = 1'b0;
    @(negedge clk);
    in_a = a; in_b = b; in_sel = sel; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin got = 1'b1; break; end
      @(negedge clk);
    end
    if (got) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL issue_timeout: in_ready stayed 0, required 1 within 20 cycles");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = 4'd0; in_b = 4'd0; in_sel = 4'd0;
    #12;
    checks++;
    if ({out_valid, out_result, out_carry, out_zero, out_err, busy, op_count} !== 17'd0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b res=%h c=%b z=%b e=%b busy=%b ops=%0d, required all 0",
               out_valid, out_result, out_carry, out_zero, out_err, busy, op_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_add_latency();
    out_ready = 1'b1;
    issue(4'd9, 4'd8, 4'd0);
    exp_ops++;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || dut_entry !== 7'b0010001) begin
      errors++;
      $display("FAIL add_latency: got valid=%b entry=%b, required valid=1 entry=0010001", out_valid, dut_entry);
    end
    checks++;
    if (op_count !== 8'(exp_ops)) begin
      errors++;
      $display("FAIL add_op_count: got %0d, required %0d", op_count, exp_ops);
    end
  endtask

  task automatic test_errors();
    logic [6:0] exp;
    out_ready = 1'b1;
    issue(4'd7, 4'd0, 4'd3);
    exp_ops++;
    @(negedge clk);
    @(negedge clk);
    exp = ref_entry(7, 0, 3);
    checks++;
    if (out_valid !== 1'b1 || dut_entry !== exp) begin
      errors++;
      $display("FAIL div_by_zero: got valid=%b entry=%b, required valid=1 entry=%b", out_valid, dut_entry, exp);
    end
    issue(4'd4, 4'd4, 4'd5);
    exp_ops++;
    @(negedge clk);
    @(negedge clk);
    exp = ref_entry(4, 4, 5);
    checks++;
    if (out_valid !== 1'b1 || dut_entry !== exp) begin
      errors++;
      $display("FAIL unsupported_op: got valid=%b entry=%b, required valid=1 entry=%b", out_valid, dut_entry, exp);
    end
    checks++;
    if (op_count !== 8'(exp_ops)) begin
      errors++;
      $display("FAIL err_op_count: got %0d, required %0d", op_count, exp_ops);
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    out_ready = 1'b0;
    issue(4'd5, 4'd5, 4'd1);
    issue(4'd3, 4'd2, 4'd14);
    exp_ops += 2;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_full_ready: got in_ready=%b, required 0", in_ready);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || dut_entry !== 7'b0100000 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_head_sub: got valid=%b entry=%b ready=%b, required 1/0100000/0", out_valid, dut_entry, in_ready);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || dut_entry !== 7'b0000001 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_head_gt: got valid=%b entry=%b ready=%b, required 1/0000001/1", out_valid, dut_entry, in_ready);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || op_count !== 8'(exp_ops)) begin
      errors++;
      $display("FAIL bp_drain: got valid=%b busy=%b ops=%0d, required 0/0/%0d", out_valid, busy, op_count, exp_ops);
    end
  endtask

  task automatic test_simul_push_pop();
    logic [6:0] eb, ec, ed;
    eb = ref_entry(6, 3, 2);
    ec = ref_entry(9, 4, 4);
    ed = ref_entry(13, 6, 7);
    out_ready = 1'b0;
    issue(4'd1, 4'd2, 4'd0);
    issue(4'd6, 4'd3, 4'd2);
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || dut_entry !== eb) begin
      errors++;
      $display("FAIL spp_head_b: got valid=%b entry=%b, required 1/%b", out_valid, dut_entry, eb);
    end
    issue(4'd9, 4'd4, 4'd4);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || dut_entry !== ec || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL spp_head_c: got valid=%b entry=%b ready=%b, required 1/%b/1", out_valid, dut_entry, in_ready, ec);
    end
    issue(4'd13, 4'd6, 4'd7);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || dut_entry !== ec) begin
      errors++;
      $display("FAIL spp_full: got ready=%b entry=%b, required 0/%b", in_ready, dut_entry, ec);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || dut_entry !== ed) begin
      errors++;
      $display("FAIL spp_head_d: got valid=%b entry=%b, required 1/%b", out_valid, dut_entry, ed);
    end
    @(negedge clk);
    out_ready = 1'b0;
    exp_ops += 4;
    checks++;
    if (out_valid !== 1'b0 || op_count !== 8'(exp_ops)) begin
      errors++;
      $display("FAIL spp_drain: got valid=%b ops=%0d, required 0/%0d", out_valid, op_count, exp_ops);
    end
  endtask

  task automatic test_reset_mid_exec();
    out_ready = 1'b1;
    issue(4'd3, 4'd3, 4'd0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_result, out_carry, out_zero, out_err, busy, op_count} !== 17'd0) begin
      errors++;
      $display("FAIL midexec_reset: got valid=%b res=%h busy=%b ops=%0d, required all 0",
               out_valid, out_result, busy, op_count);
    end
    exp_ops = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midexec_in_ready: got %b, required 1", in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || op_count !== 8'd0) begin
        errors++;
        $display("FAIL midexec_no_result: cycle %0d got valid=%b ops=%0d, required 0/0", i, out_valid, op_count);
      end
    end
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      issue(4'($urandom), 4'($urandom), 4'($urandom));
      if (i == 254) begin
        @(negedge clk);
        checks++;
        if (op_count !== 8'd255) begin
          errors++;
          $display("FAIL wrap_255: got %0d, required 255", op_count);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (op_count !== 8'd0) begin
      errors++;
      $display("FAIL wrap_zero: got %0d, required 0", op_count);
    end
  endtask

  task automatic test_random();
    logic [6:0] q[$];
    logic [6:0] exec_entry;
    bit exec, hidden, exp_ready, exp_valid, acc, pop, was_empty;
    int ops;
    int sup[8] = '{0, 1, 2, 3, 4, 7, 8, 14};
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exec = 0; hidden = 0; ops = 0; exec_entry = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      exp_ready = !exec && (q.size() < 2);
      exp_valid = (q.size() > 0) && !hidden;
      checks++;
      if (in_ready !== exp_ready || out_valid !== exp_valid || busy !== (exec || q.size() > 0)) begin
        errors++;
        $display("FAIL rand_ctrl: cycle %0d got ready=%b valid=%b busy=%b, required %b/%b/%b",
                 cyc, in_ready, out_valid, busy, exp_ready, exp_valid, (exec || q.size() > 0));
      end
      if (exp_valid) begin
        checks++;
        if (dut_entry !== q[0]) begin
          errors++;
          $display("FAIL rand_entry: cycle %0d got %b, required %b", cyc, dut_entry, q[0]);
        end
      end
      checks++;
      if (op_count !== 8'(ops)) begin
        errors++;
        $display("FAIL rand_op_count: cycle %0d got %0d, required %0d", cyc, op_count, ops % 256);
      end
      in_valid  = ($urandom % 3) != 0;
      in_a      = 4'($urandom);
      in_b      = ($urandom % 4 == 0) ? 4'd0 : 4'($urandom);
      in_sel    = ($urandom % 4 == 0) ? 4'($urandom) : 4'(sup[$urandom % 8]);
      out_ready = ($urandom % 4) != 0;
      acc = in_valid && exp_ready;
      pop = exp_valid && out_ready;
      was_empty = (q.size() == 0);
      if (pop) void'(q.pop_front());
      if (exec) begin
        q.push_back(exec_entry);
        ops++;
      end
      hidden = exec && was_empty;
      exec = acc;
      if (acc) exec_entry = ref_entry(in_a, in_b, in_sel);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add_latency();
    test_errors();
    test_backpressure();
    test_simul_push_pop();
    test_reset_mid_exec();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
